// File: rtl/demux_router_1to3.sv
// 1-to-3 valid/ready demultiplexer: one source fans out to three one-entry
// registered channels; SEL=3 words are dropped and counted (saturating).
module demux_router_chan #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  input  logic             ready,
  output logic [WIDTH-1:0] q,
  output logic             valid,
  output logic             avail
);
  // slot can take a word if empty, or if it drains this same cycle
  assign avail = ~valid | ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      q     <= '0;
      valid <= 1'b0;
    end else if (load) begin
      q     <= d;
      valid <= 1'b1;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end
endmodule

module demux_router_1to3 #(
  parameter int WIDTH = 2,
  parameter int CNT_W = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] X,
  input  logic [1:0]       SEL,
  input  logic             X_VALID,
  output logic             X_READY,
  output logic [WIDTH-1:0] OA,
  output logic [WIDTH-1:0] OB,
  output logic [WIDTH-1:0] OC,
  output logic             OA_VALID,
  output logic             OB_VALID,
  output logic             OC_VALID,
  input  logic             OA_READY,
  input  logic             OB_READY,
  input  logic             OC_READY,
  output logic [CNT_W-1:0] DROP_CNT
);
  localparam int NUM_LANES = 3;

  logic [NUM_LANES-1:0][WIDTH-1:0] q;
  logic [NUM_LANES-1:0]            vld, rdy, avail, load;
  logic                            accept;
  logic [CNT_W-1:0]                drop_cnt;

  assign rdy = {OC_READY, OB_READY, OA_READY};

  always_comb begin
    X_READY = 1'b0;
    if (!RST) begin
      case (SEL)
        2'd0:    X_READY = avail[0];
        2'd1:    X_READY = avail[1];
        2'd2:    X_READY = avail[2];
        default: X_READY = 1'b1;
      endcase
    end
  end

  assign accept = X_VALID & X_READY;

  genvar k;
  generate
    for (k = 0; k < NUM_LANES; k++) begin : g_chan
      assign load[k] = accept & (SEL == 2'(k));
      demux_router_chan #(.WIDTH(WIDTH)) u_chan (
        .clk   (CLK),
        .rst   (RST),
        .load  (load[k]),
        .d     (X),
        .ready (rdy[k]),
        .q     (q[k]),
        .valid (vld[k]),
        .avail (avail[k])
      );
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST)
      drop_cnt <= '0;
    else if (accept && SEL == 2'd3 && drop_cnt != '1)
      drop_cnt <= drop_cnt + 1'b1;
  end

  assign OA       = q[0];
  assign OB       = q[1];
  assign OC       = q[2];
  assign OA_VALID = vld[0];
  assign OB_VALID = vld[1];
  assign OC_VALID = vld[2];
  assign DROP_CNT = drop_cnt;
endmodule

// File: tb/tb_demux_router_1to3.sv
// Bench for demux_router_1to3: directed vector table, a sustained-throughput
// sequence, then random traffic against a per-channel slot model.
module tb_demux_router_1to3;
  localparam int WIDTH = 2;
  localparam int CNT_W = 2;

  logic             clk = 1'b0;
  logic             rst, x_valid, x_ready;
  logic [WIDTH-1:0] x, oa, ob, oc;
  logic [1:0]       sel;
  logic             oa_valid, ob_valid, oc_valid;
  logic             oa_ready, ob_ready, oc_ready;
  logic [CNT_W-1:0] drop_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  demux_router_1to3 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .CLK(clk), .RST(rst), .X(x), .SEL(sel), .X_VALID(x_valid), .X_READY(x_ready),
    .OA(oa), .OB(ob), .OC(oc),
    .OA_VALID(oa_valid), .OB_VALID(ob_valid), .OC_VALID(oc_valid),
    .OA_READY(oa_ready), .OB_READY(ob_ready), .OC_READY(oc_ready),
    .DROP_CNT(drop_cnt)
  );

  typedef struct {
    logic       rst, xv;
    logic [1:0] sel, x;
    logic [2:0] rdy;   // {C,B,A}
    logic       xr;    // expected X_READY before the edge
    logic [2:0] v;     // expected valids after the edge {C,B,A}
    logic [1:0] oa, ob, oc;
    logic [2:0] m;     // which data outputs are meaningful after the edge
    logic [1:0] cnt;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, input logic xv, input logic [1:0] s, input logic [1:0] xx,
                     input logic [2:0] rd, input logic xr, input logic [2:0] v,
                     input logic [1:0] a, input logic [1:0] b, input logic [1:0] c,
                     input logic [2:0] m, input logic [1:0] cnt);
    vec_t e;
    e.rst = r; e.xv = xv; e.sel = s; e.x = xx; e.rdy = rd; e.xr = xr; e.v = v;
    e.oa = a; e.ob = b; e.oc = c; e.m = m; e.cnt = cnt;
    tbl.push_back(e);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic xv, input logic [1:0] s,
                       input logic [1:0] xx, input logic [2:0] rd);
    rst = r; x_valid = xv; sel = s; x = xx;
    {oc_ready, ob_ready, oa_ready} = rd;
  endtask

  // reference model: three one-word slots and a saturating drop tally
  logic [1:0] mdata [3];
  logic       mvalid[3];
  int         mdrops;

  function automatic logic model_ready(input logic r, input logic [1:0] s, input logic [2:0] rd);
    if (r) return 1'b0;
    if (s == 2'd3) return 1'b1;
    return !mvalid[s] || rd[s];
  endfunction

  task automatic model_step(input logic r, input logic xv, input logic [1:0] s,
                            input logic [1:0] xx, input logic [2:0] rd);
    logic acc;
    acc = xv && model_ready(r, s, rd);
    if (r) begin
      for (int i = 0; i < 3; i++) begin mvalid[i] = 1'b0; mdata[i] = 2'd0; end
      mdrops = 0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (acc && s == 2'(i)) begin mdata[i] = xx; mvalid[i] = 1'b1; end
      else if (mvalid[i] && rd[i]) mvalid[i] = 1'b0;
    end
    if (acc && s == 2'd3) mdrops = (mdrops < 3) ? mdrops + 1 : 3;
  endtask

  initial begin
    drive(1, 0, 0, 0, 3'b000);
    // reset with a valid word pending
    add(1,1,0,3, 3'b000, 0, 3'b000, 0,0,0, 3'b111, 0);
    add(1,1,0,3, 3'b000, 0, 3'b000, 0,0,0, 3'b111, 0);
    // routing A, B, C
    add(0,1,0,1, 3'b111, 1, 3'b001, 1,0,0, 3'b001, 0);
    add(0,1,1,2, 3'b111, 1, 3'b010, 0,2,0, 3'b010, 0);
    add(0,1,2,3, 3'b111, 1, 3'b100, 0,0,3, 3'b100, 0);
    add(0,0,0,0, 3'b111, 1, 3'b000, 0,0,0, 3'b000, 0);
    // backpressure on B, then pass-through
    add(0,1,1,2, 3'b101, 1, 3'b010, 0,2,0, 3'b010, 0);
    add(0,1,1,1, 3'b101, 0, 3'b010, 0,2,0, 3'b010, 0);
    add(0,1,1,1, 3'b111, 1, 3'b010, 0,1,0, 3'b010, 0);
    // independence: A stalled, C still flows
    add(0,1,0,1, 3'b110, 1, 3'b001, 1,0,0, 3'b001, 0);
    add(0,1,2,3, 3'b110, 1, 3'b101, 1,0,3, 3'b101, 0);
    add(0,1,0,2, 3'b110, 0, 3'b001, 1,0,0, 3'b001, 0);
    // drops saturate at 3
    add(0,1,3,0, 3'b110, 1, 3'b001, 1,0,0, 3'b001, 1);
    add(0,1,3,1, 3'b110, 1, 3'b001, 1,0,0, 3'b001, 2);
    add(0,1,3,2, 3'b110, 1, 3'b001, 1,0,0, 3'b001, 3);
    add(0,1,3,3, 3'b110, 1, 3'b001, 1,0,0, 3'b001, 3);
    add(0,1,3,0, 3'b110, 1, 3'b001, 1,0,0, 3'b001, 3);
    // fill all channels, reset mid-operation, accept right after
    add(0,1,1,2, 3'b000, 1, 3'b011, 1,2,0, 3'b011, 3);
    add(0,1,2,1, 3'b000, 1, 3'b111, 1,2,1, 3'b111, 3);
    add(1,1,0,3, 3'b000, 0, 3'b000, 0,0,0, 3'b111, 0);
    add(0,1,0,2, 3'b000, 1, 3'b001, 2,0,0, 3'b001, 0);
    add(0,0,0,0, 3'b111, 1, 3'b000, 0,0,0, 3'b000, 0);

    foreach (tbl[i]) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].xv, tbl[i].sel, tbl[i].x, tbl[i].rdy);
      #1 chk($sformatf("v%0d.x_ready", i), 32'(x_ready), 32'(tbl[i].xr));
      @(posedge clk); #1;
      chk($sformatf("v%0d.valids", i), 32'({oc_valid, ob_valid, oa_valid}), 32'(tbl[i].v));
      if (tbl[i].m[0]) chk($sformatf("v%0d.oa", i), 32'(oa), 32'(tbl[i].oa));
      if (tbl[i].m[1]) chk($sformatf("v%0d.ob", i), 32'(ob), 32'(tbl[i].ob));
      if (tbl[i].m[2]) chk($sformatf("v%0d.oc", i), 32'(oc), 32'(tbl[i].oc));
      chk($sformatf("v%0d.drop_cnt", i), 32'(drop_cnt), 32'(tbl[i].cnt));
    end

    // sustained 1 word/cycle on A with READY held high: VALID never drops
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      drive(0, 1, 0, 2'(i), 3'b001);
      @(posedge clk); #1;
      chk($sformatf("stream%0d.oa_valid", i), 32'(oa_valid), 32'd1);
      chk($sformatf("stream%0d.oa", i), 32'(oa), 32'(i));
    end

    // random traffic against the slot model, starting from reset
    @(negedge clk);
    drive(1, 0, 0, 0, 3'b000);
    model_step(1, 0, 0, 0, 3'b000);
    @(posedge clk);
    for (int n = 0; n < 300; n++) begin
      logic       r, xv;
      logic [1:0] s, xx;
      logic [2:0] rd;
      @(negedge clk);
      r  = ($urandom_range(0, 31) == 0);
      xv = $urandom_range(0, 3) != 0;
      s  = 2'($urandom_range(0, 3));
      xx = 2'($urandom_range(0, 3));
      rd = 3'($urandom_range(0, 7));
      drive(r, xv, s, xx, rd);
      #1 chk($sformatf("r%0d.x_ready", n), 32'(x_ready), 32'(model_ready(r, s, rd)));
      model_step(r, xv, s, xx, rd);
      @(posedge clk); #1;
      chk($sformatf("r%0d.valids", n), 32'({oc_valid, ob_valid, oa_valid}),
          32'({mvalid[2], mvalid[1], mvalid[0]}));
      if (mvalid[0]) chk($sformatf("r%0d.oa", n), 32'(oa), 32'(mdata[0]));
      if (mvalid[1]) chk($sformatf("r%0d.ob", n), 32'(ob), 32'(mdata[1]));
      if (mvalid[2]) chk($sformatf("r%0d.oc", n), 32'(oc), 32'(mdata[2]));
      chk($sformatf("r%0d.drop_cnt", n), 32'(drop_cnt), 32'(mdrops));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
